// File: rtl/compuertas_sweep_if.sv
// Bundle between the sweep sequencer, its controller and the gate block.
// master: controller/gate side; slave: compuertas_sweep.
interface compuertas_sweep_if;
    logic       start;
    logic [7:0] exp_s1;
    logic [7:0] exp_s2;
    logic       A;
    logic       B;
    logic       C;
    logic       S1;
    logic       S2;
    logic       busy;
    logic       done;
    logic [7:0] tt_s1;
    logic [7:0] tt_s2;
    logic [3:0] err_count;
    logic       pass;

    modport master (
        output start, exp_s1, exp_s2, S1, S2,
        input  A, B, C, busy, done,
        input  tt_s1, tt_s2, err_count, pass
    );

    modport slave (
        input  start, exp_s1, exp_s2, S1, S2,
        output A, B, C, busy, done,
        output tt_s1, tt_s2, err_count, pass
    );
endinterface

// File: rtl/compuertas_sweep.sv
// Exhaustive sweep of {A,B,C} over 0..7, capturing S1/S2 truth tables.
// Ports: clk, rst_n (async, active low), bus (slave: start/exp in,
// A/B/C drive, S1/S2 sample, busy/done/tables/err_count/pass out).
module compuertas_sweep #(
    parameter int unsigned HOLD_CYCLES = 2
) (
    input logic              clk,
    input logic              rst_n,
    compuertas_sweep_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_e;

    localparam logic [7:0] LAST = 8'(HOLD_CYCLES - 1);

    state_e     state_q, state_d;
    logic [2:0] vec_q, vec_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] abc_q, abc_d;
    logic [7:0] exp1_q, exp1_d;
    logic [7:0] exp2_q, exp2_d;
    logic [7:0] tt1_q, tt1_d;
    logic [7:0] tt2_q, tt2_d;
    logic [3:0] err_q, err_d;
    logic       pass_q, pass_d;

    logic [1:0] inc;
    logic [4:0] err_sum;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        abc_d   = abc_q;
        exp1_d  = exp1_q;
        exp2_d  = exp2_q;
        tt1_d   = tt1_q;
        tt2_d   = tt2_q;
        err_d   = err_q;
        pass_d  = pass_q;
        inc     = 2'd0;
        err_sum = 5'd0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = DRIVE;
                    vec_d   = 3'd0;
                    cnt_d   = 8'd0;
                    abc_d   = 3'd0;
                    exp1_d  = bus.exp_s1;
                    exp2_d  = bus.exp_s2;
                    tt1_d   = 8'd0;
                    tt2_d   = 8'd0;
                    err_d   = 4'd0;
                    pass_d  = 1'b0;
                end
            end
            DRIVE: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == LAST) begin
                    tt1_d[vec_q] = bus.S1;
                    tt2_d[vec_q] = bus.S2;
                    inc = {1'b0, bus.S1 != exp1_q[vec_q]}
                        + {1'b0, bus.S2 != exp2_q[vec_q]};
                    err_sum = {1'b0, err_q} + {3'b0, inc};
                    // 16 mismatches do not fit in 4 bits: clamp.
                    err_d = err_sum[4] ? 4'hF : err_sum[3:0];
                    if (vec_q == 3'd7) begin
                        state_d = DONE;
                        abc_d   = 3'd0;
                        pass_d  = (err_sum == 5'd0);
                    end else begin
                        vec_d = vec_q + 3'd1;
                        abc_d = vec_q + 3'd1;
                        cnt_d = 8'd0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= 3'd0;
            cnt_q   <= 8'd0;
            abc_q   <= 3'd0;
            exp1_q  <= 8'd0;
            exp2_q  <= 8'd0;
            tt1_q   <= 8'd0;
            tt2_q   <= 8'd0;
            err_q   <= 4'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            abc_q   <= abc_d;
            exp1_q  <= exp1_d;
            exp2_q  <= exp2_d;
            tt1_q   <= tt1_d;
            tt2_q   <= tt2_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end

    assign bus.A         = abc_q[2];
    assign bus.B         = abc_q[1];
    assign bus.C         = abc_q[0];
    assign bus.busy      = (state_q == DRIVE);
    assign bus.done      = (state_q == DONE);
    assign bus.tt_s1     = tt1_q;
    assign bus.tt_s2     = tt2_q;
    assign bus.err_count = err_q;
    assign bus.pass      = pass_q;
endmodule

// File: tb/tb_compuertas_sweep.sv
// Randomized bench for compuertas_sweep at HOLD_CYCLES=2 and 1.
// Both instances see the same gate truth tables and expectations.
module tb_compuertas_sweep;
    logic clk = 1'b0;
    logic rst_n;
    logic [7:0] g1, g2;

    int n_chk  = 0;
    int n_fail = 0;

    compuertas_sweep_if if2 ();
    compuertas_sweep_if if1 ();

    compuertas_sweep #(.HOLD_CYCLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2.slave)
    );
    compuertas_sweep #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave)
    );

    always #5 clk = ~clk;

    logic [2:0] idx2, idx1;
    assign idx2   = {if2.A, if2.B, if2.C};
    assign idx1   = {if1.A, if1.B, if1.C};
    assign if2.S1 = g1[idx2];
    assign if2.S2 = g2[idx2];
    assign if1.S1 = g1[idx1];
    assign if1.S2 = g2[idx1];

    task automatic check_eq(input string tag,
                            input logic [31:0] obs,
                            input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string nm, input logic busy,
                              input logic done, input logic [2:0] abc,
                              input logic [7:0] t1, input logic [7:0] t2,
                              input logic [3:0] err, input logic pass);
        check_eq({nm, ".rst.busy"}, 32'(busy), 32'd0);
        check_eq({nm, ".rst.done"}, 32'(done), 32'd0);
        check_eq({nm, ".rst.abc"}, 32'(abc), 32'd0);
        check_eq({nm, ".rst.tt"}, {16'd0, t1, t2}, 32'd0);
        check_eq({nm, ".rst.err"}, 32'(err), 32'd0);
        check_eq({nm, ".rst.pass"}, 32'(pass), 32'd0);
    endtask

    // Reference: cycle t after the accepting edge, hold h.
    task automatic check_dut(input string nm, input int h, input int t,
                             input logic busy, input logic done,
                             input logic [2:0] abc,
                             input logic [7:0] t1, input logic [7:0] t2,
                             input logic [3:0] err, input logic pass,
                             input logic [7:0] e1, input logic [7:0] e2);
        int mism;
        int xerr;
        string s;
        s = $sformatf("%s.t%0d", nm, t);
        if (t < 8 * h) begin
            check_eq({s, ".busy"}, 32'(busy), 32'd1);
            check_eq({s, ".done"}, 32'(done), 32'd0);
            check_eq({s, ".abc"}, 32'(abc), 32'(t / h));
        end else begin
            check_eq({s, ".busy"}, 32'(busy), 32'd0);
            check_eq({s, ".done"}, 32'(done), 32'(t == 8 * h));
            if (t == 8 * h || t == 8 * h + 1 || t == 16) begin
                mism = $countones(g1 ^ e1) + $countones(g2 ^ e2);
                xerr = (mism > 15) ? 15 : mism;
                check_eq({s, ".tt1"}, 32'(t1), 32'(g1));
                check_eq({s, ".tt2"}, 32'(t2), 32'(g2));
                check_eq({s, ".err"}, 32'(err), 32'(xerr));
                check_eq({s, ".pass"}, 32'(pass), 32'(mism == 0));
            end
        end
    endtask

    task automatic set_start(input logic v);
        if2.start = v;
        if1.start = v;
    endtask

    task automatic set_exp(input logic [7:0] e1, input logic [7:0] e2);
        if2.exp_s1 = e1;
        if2.exp_s2 = e2;
        if1.exp_s1 = e1;
        if1.exp_s2 = e2;
    endtask

    // Starts one sweep on both instances from a negedge in IDLE.
    task automatic run_sweep(input logic [7:0] t1, input logic [7:0] t2,
                             input logic [7:0] e1, input logic [7:0] e2,
                             input bit noise, input int abort_at);
        g1 = t1;
        g2 = t2;
        set_exp(e1, e2);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        // Later expectation changes must not disturb this sweep.
        set_exp(~e1, 8'($urandom));
        for (int t = 0; t <= 16; t++) begin
            if (t == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_zero("h2", if2.busy, if2.done,
                           {if2.A, if2.B, if2.C}, if2.tt_s1, if2.tt_s2,
                           if2.err_count, if2.pass);
                check_zero("h1", if1.busy, if1.done,
                           {if1.A, if1.B, if1.C}, if1.tt_s1, if1.tt_s2,
                           if1.err_count, if1.pass);
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                return;
            end
            check_dut("h2", 2, t, if2.busy, if2.done,
                      {if2.A, if2.B, if2.C}, if2.tt_s1, if2.tt_s2,
                      if2.err_count, if2.pass, e1, e2);
            check_dut("h1", 1, t, if1.busy, if1.done,
                      {if1.A, if1.B, if1.C}, if1.tt_s1, if1.tt_s2,
                      if1.err_count, if1.pass, e1, e2);
            set_start(noise && (t == 3 || t == 7 || t == 8));
            @(negedge clk);
        end
    endtask

    logic [7:0] nom1, nom2;
    logic [7:0] r1, r2, x1, x2;

    initial begin
        rst_n = 1'b0;
        g1 = 8'd0;
        g2 = 8'd0;
        set_start(1'b1);
        set_exp(8'hA5, 8'h5A);
        repeat (3) @(negedge clk);
        check_zero("h2", if2.busy, if2.done, {if2.A, if2.B, if2.C},
                   if2.tt_s1, if2.tt_s2, if2.err_count, if2.pass);
        check_zero("h1", if1.busy, if1.done, {if1.A, if1.B, if1.C},
                   if1.tt_s1, if1.tt_s2, if1.err_count, if1.pass);
        rst_n = 1'b1;
        set_start(1'b0);
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            logic a, b, c;
            {a, b, c} = 3'(i);
            nom1[i] = (a & b) | c;
            nom2[i] = a ^ b;
        end

        run_sweep(nom1, nom2, 8'hEA, 8'h3C, 1'b0, -1);
        run_sweep(nom1, nom2, 8'hEB, 8'h3D, 1'b0, -1);
        run_sweep(8'h00, 8'h00, 8'hFF, 8'hFF, 1'b0, -1);
        run_sweep(nom1, nom2, 8'hEA, 8'h3C, 1'b1, -1);
        run_sweep(nom1, nom2, 8'hEA, 8'h3C, 1'b0, 8);
        run_sweep(nom1, nom2, 8'hEA, 8'h3C, 1'b0, -1);

        for (int n = 0; n < 24; n++) begin
            r1 = 8'($urandom);
            r2 = 8'($urandom);
            x1 = ($urandom_range(0, 2) == 0) ? r1 : 8'($urandom);
            x2 = ($urandom_range(0, 2) == 0) ? r2 : r2 ^ 8'($urandom);
            run_sweep(r1, r2, x1, x2, n[0], -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
